ram_burst_ctrl: RTL and testbench

Burst controller sitting directly upstream of the single-port synchronous RAM. It accepts a burst command (direction, base address, length) and drives the RAM's WE/RE/addr/WD pins. Write data arrives on a valid/ready stream; read data leaves on a valid-qualified stream. Bursts use incrementing addresses that wrap modulo DEPTH.

---
 rtl/ram_burst_ctrl.sv | 107 ++++++++++
 tb/tb_ram_burst_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst controller driving a single-port synchronous RAM from
//               a write stream (valid/ready) and onto a read stream (valid).
// Revision    : 1.0 - initial release
// ============================================================================

module ram_burst_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [ADDR-1:0]  base,
    input  logic [ADDR-1:0]  len,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             ram_we,
    output logic             ram_re,
    output logic [ADDR-1:0]  ram_addr,
    output logic [WIDTH-1:0] ram_wd,
    input  logic [WIDTH-1:0] ram_rd
);

    localparam logic [1:0]      S_IDLE  = 2'd0;
    localparam logic [1:0]      S_WRITE = 2'd1;
    localparam logic [1:0]      S_READ  = 2'd2;
    localparam logic [1:0]      S_DRAIN = 2'd3;
    localparam logic [ADDR-1:0] C_ONE   = {{(ADDR-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [ADDR-1:0] r_addr;
    logic [ADDR-1:0] r_cnt;
    logic            r_done;
    logic            r_rd_valid;
    logic [ADDR-1:0] w_addr_inc;

    // Bursts wrap around the RAM rather than running off its end.
    assign w_addr_inc = ADDR'((32'(r_addr) + 32'd1) % DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= (r_state == S_READ);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base;
                        r_cnt   <= len;
                        r_state <= rw ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        r_addr <= w_addr_inc;
                        r_cnt  <= r_cnt - C_ONE;
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_addr <= w_addr_inc;
                    r_cnt  <= r_cnt - C_ONE;
                    if (r_cnt == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Lets the final read word reach rd_data before done.
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign wr_ready = (r_state == S_WRITE);
    assign ram_we   = (r_state == S_WRITE) && wr_valid;
    assign ram_re   = (r_state == S_READ);
    assign ram_addr = r_addr;
    assign ram_wd   = wr_data;
    assign rd_valid = r_rd_valid;
    assign rd_data  = ram_rd;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Randomised self-checking bench for ram_burst_ctrl with a RAM
//               model and an array-based reference of expected contents.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ram_burst_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             rw = 1'b0;
    logic [ADDR-1:0]  base = '0;
    logic [ADDR-1:0]  len = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             ram_we;
    logic             ram_re;
    logic [ADDR-1:0]  ram_addr;
    logic [WIDTH-1:0] ram_wd;
    logic [WIDTH-1:0] ram_rd = '0;

    logic [WIDTH-1:0] ram_mem [DEPTH];
    int               ref_mem [DEPTH];
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_wd   (ram_wd),
        .ram_rd   (ram_rd)
    );

    // Single-port synchronous RAM the controller is meant to drive.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wd;
        if (ram_re) ram_rd <= ram_mem[ram_addr];
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // mode 0: wr_valid always high, 1: gaps on 2nd/4th cycle, 2: random gaps.
    task automatic write_burst(input int b, input int l, input int mode,
                               input bit fixed, input int abort_at, input bit mid_start);
        int k = 0;
        int c = 0;
        int a;
        @(negedge clk);
        start = 1'b1; rw = 1'b1; base = ADDR'(b); len = ADDR'(l);
        @(negedge clk);
        start = 1'b0;
        while (k <= l && c < 8 * DEPTH) begin
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = !(c == 1 || c == 3);
                default: wr_valid = ($urandom_range(0, 2) != 0);
            endcase
            wr_data = fixed ? WIDTH'(10 + k) : WIDTH'($urandom);
            if (mid_start && c == 1) begin
                start = 1'b1; rw = 1'($urandom); base = ADDR'($urandom); len = ADDR'($urandom);
            end else begin
                start = 1'b0;
            end
            a = (b + k) % DEPTH;
            #1;
            check_eq("wr_busy", int'(busy), 1);
            check_eq("wr_ready", int'(wr_ready), 1);
            check_eq("wr_we", int'(ram_we), int'(wr_valid));
            check_eq("wr_re", int'(ram_re), 0);
            check_eq("wr_addr", int'(ram_addr), a);
            check_eq("wr_wd", int'(ram_wd), int'(wr_data));
            check_eq("wr_done", int'(done), 0);
            if (wr_valid) begin
                ref_mem[a] = int'(wr_data);
                if (k == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    check_eq("abort_busy", int'(busy), 0);
                    check_eq("abort_we", int'(ram_we), 0);
                    check_eq("abort_ready", int'(wr_ready), 0);
                    check_eq("abort_addr", int'(ram_addr), 0);
                    check_eq("abort_done", int'(done), 0);
                    @(negedge clk);
                    check_eq("abort_done2", int'(done), 0);
                    check_eq("abort_we2", int'(ram_we), 0);
                    wr_valid = 1'b0;
                    return;
                end
                k++;
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        wr_valid = 1'b0;
        #1;
        check_eq("wr_timeout", int'(k > l), 1);
        check_eq("wr_end_done", int'(done), 1);
        check_eq("wr_end_busy", int'(busy), 0);
        check_eq("wr_end_ready", int'(wr_ready), 0);
    endtask

    task automatic read_burst(input int b, input int l);
        start = 1'b1; rw = 1'b0; base = ADDR'(b); len = ADDR'(l);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= l + 1; i++) begin
            #1;
            check_eq("rd_busy", int'(busy), 1);
            check_eq("rd_re", int'(ram_re), int'(i <= l));
            check_eq("rd_we", int'(ram_we), 0);
            check_eq("rd_ready", int'(wr_ready), 0);
            if (i <= l) check_eq("rd_addr", int'(ram_addr), (b + i) % DEPTH);
            check_eq("rd_valid", int'(rd_valid), int'(i > 0));
            if (i > 0) check_eq("rd_data", int'(rd_data), ref_mem[(b + i - 1) % DEPTH]);
            check_eq("rd_done", int'(done), 0);
            @(negedge clk);
        end
        #1;
        check_eq("rd_end_done", int'(done), 1);
        check_eq("rd_end_busy", int'(busy), 0);
        check_eq("rd_end_valid", int'(rd_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = WIDTH'($urandom);
            ref_mem[i] = int'(ram_mem[i]);
        end
        repeat (2) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rd_valid", int'(rd_valid), 0);
        check_eq("rst_ready", int'(wr_ready), 0);
        check_eq("rst_we", int'(ram_we), 0);
        check_eq("rst_re", int'(ram_re), 0);
        check_eq("rst_addr", int'(ram_addr), 0);
        rst = 1'b0;

        write_burst(4, 3, 0, 1'b1, -1, 1'b0);
        write_burst(4, 3, 1, 1'b1, -1, 1'b0);
        read_burst(4, 3);
        write_burst(14, 3, 2, 1'b0, -1, 1'b0);
        read_burst(14, 3);
        write_burst(8, 5, 0, 1'b0, -1, 1'b1);
        read_burst(8, 5);
        write_burst(2, 6, 0, 1'b0, 2, 1'b0);
        write_burst(1, 2, 2, 1'b0, -1, 1'b0);
        read_burst(0, 7);
        write_burst(0, 15, 2, 1'b0, -1, 1'b0);
        read_burst(0, 15);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                write_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                            $urandom_range(0, 2), 1'b0, -1, 1'($urandom));
            else
                read_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        read_burst(0, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
